arqt1_pio_in: RTL and testbench

ARQT1_PIO_IN -- requirements
Module: arqt1_pio_in

---
 rtl/arqt1_pio_pkg.sv | 35 +++
 rtl/arqt1_pio_in_debounce.sv | 65 ++++++
 rtl/arqt1_pio_in.sv | 88 ++++++++
 tb/tb_arqt1_pio_in.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arqt1_pio_pkg.sv
// arqt1_pio_pkg
//   Shared constants for the arqt1 parallel input port.
//   - Avalon-MM word addresses of the register map.
//   - EDGE_TYPE encodings for edge capture.
//   - Helpers: debounce counter width, edge qualification.
package arqt1_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Counter must hold 0..cycles; a zero-cycle debounce still needs one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // True when the debounced level moved from prev to cur in the selected direction.
  function automatic logic edge_hit(input int edge_type, input logic cur, input logic prev);
    logic hit;
    case (edge_type)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      default:   hit = cur ^ prev;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/arqt1_pio_in_debounce.sv
// arqt1_pio_debounce
//   One input pin: 2-flop synchronizer, saturating debounce counter,
//   debounced level and a one-cycle qualified edge pulse.
// Ports
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   i_pin    : raw asynchronous pin
//   o_level  : debounced level (registered)
//   o_edge   : high for the one cycle after o_level changed in the selected direction
module arqt1_pio_debounce
  import arqt1_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = EDGE_RISE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_edge
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_prev;
  logic [CW-1:0] r_cnt;

  logic w_differ;
  logic w_accept;

  assign w_differ = r_sync2 ^ r_level;
  // Counter has already seen DEBOUNCE_CYCLES disagreeing cycles; this one completes the run.
  assign w_accept = w_differ && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_level      <= 1'b0;
      r_level_prev <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_sync1      <= i_pin;
      r_sync2      <= r_sync1;
      r_level_prev <= r_level;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_edge  = edge_hit(EDGE_TYPE, r_level, r_level_prev);

endmodule

// File: rtl/arqt1_pio_in.sv
// arqt1_pio_in
//   Debounced parallel input port with edge capture and level interrupt,
//   Avalon-MM slave, zero wait states / zero read latency.
// Ports
//   clk, reset_n : clock, asynchronous active-low reset
//   address      : word address (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE)
//   chipselect   : slave select (writes only; reads are unconditional)
//   write_n      : active-low write strobe
//   writedata    : write data
//   in_port      : asynchronous external pins
//   readdata     : combinational read data
//   irq          : OR of captured edges that are unmasked
module arqt1_pio_in
  import arqt1_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_edge;
  logic             w_wr;
  logic             w_unused_wdata;

  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      arqt1_pio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .EDGE_TYPE      (EDGE_TYPE)
      ) u_deb (
        .clk    (clk),
        .reset_n(reset_n),
        .i_pin  (in_port[gi]),
        .o_level(w_level[gi]),
        .o_edge (w_edge[gi])
      );
    end
  endgenerate

  assign w_wr = chipselect & ~write_n;
  // Bits above WIDTH are intentionally ignored on writes.
  assign w_unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      if (w_wr && (address == ADDR_IRQMASK)) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
      // Clear is applied first so a simultaneous new edge wins.
      if (w_wr && (address == ADDR_EDGECAP)) begin
        r_edgecap <= (r_edgecap & ~writedata[WIDTH-1:0]) | w_edge;
      end else begin
        r_edgecap <= r_edgecap | w_edge;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = w_level;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = r_edgecap;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_arqt1_pio_in.sv
// Bench for arqt1_pio_in: three instances with different debounce/edge settings
// share one bus and one pin vector; a window-based reference model predicts
// readdata and irq every cycle, and a monitor compares them on the falling edge.
module tb_arqt1_pio_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  logic [2:0][31:0] dut_rd;
  logic [2:0]       dut_irq;
  assign dut_rd  = {rd2, rd1, rd0};
  assign dut_irq = {irq2, irq1, irq0};

  arqt1_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));

  arqt1_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(3), .EDGE_TYPE(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1));

  arqt1_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dcyc(input int j);
    return (j == 0) ? 0 : (j == 1) ? 3 : 1;
  endfunction

  function automatic int etyp(input int j);
    return (j == 0) ? 0 : (j == 1) ? 2 : 1;
  endfunction

  // Reference model state
  logic [3:0] m_deb  [3];
  logic [3:0] m_prev [3];
  logic [3:0] m_ecap [3];
  logic [3:0] m_mask [3];
  logic [3:0] hist [$];   // hist[0] = pins sampled at the latest edge

  typedef struct packed {
    logic             cs;
    logic             wn;
    logic [1:0]       addr;
    logic [31:0]      wd;
    logic [2:0][31:0] rd;
    logic [2:0]       irq;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [3:0] cur_pins = 4'h0;

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      m_deb[j] = '0; m_prev[j] = '0; m_ecap[j] = '0; m_mask[j] = '0;
    end
    hist = {};
    for (int i = 0; i < 8; i++) hist.push_back(4'h0);
  endtask

  // One clock edge of the model, using the inputs currently driven.
  // A bit's debounced level flips once the last DEBOUNCE+1 synchronized samples
  // (pins delayed two edges) all disagree with it.
  task automatic model_edge();
    logic [3:0] pulse, nd, ec;
    bit flip;
    int d;
    if (reset_n !== 1'b1) return;
    for (int j = 0; j < 3; j++) begin
      d = dcyc(j);
      case (etyp(j))
        0:       pulse = m_deb[j] & ~m_prev[j];
        1:       pulse = ~m_deb[j] & m_prev[j];
        default: pulse = m_deb[j] ^ m_prev[j];
      endcase
      ec = m_ecap[j];
      if (chipselect && !write_n && address == 2'd3) ec = ec & ~writedata[3:0];
      m_ecap[j] = ec | pulse;
      if (chipselect && !write_n && address == 2'd2) m_mask[j] = writedata[3:0];
      nd = m_deb[j];
      for (int b = 0; b < 4; b++) begin
        flip = 1'b1;
        for (int i = 1; i <= d + 1; i++)
          if (hist[i][b] == m_deb[j][b]) flip = 1'b0;
        if (flip) nd[b] = ~m_deb[j][b];
      end
      m_prev[j] = m_deb[j];
      m_deb[j]  = nd;
    end
    hist.push_front(in_port);
    void'(hist.pop_back());
  endtask

  function automatic logic [31:0] model_rd(input int j, input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0:    v[3:0] = m_deb[j];
      2'd2:    v[3:0] = m_mask[j];
      2'd3:    v[3:0] = m_ecap[j];
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic step(input logic rst_v, input logic [3:0] pins, input logic cs,
                      input logic wn, input logic [1:0] a, input logic [31:0] wd);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    reset_n = rst_v;
    if (!rst_v) model_reset();
    in_port = pins; chipselect = cs; write_n = wn; address = a; writedata = wd;
    e.cs = cs; e.wn = wn; e.addr = a; e.wd = wd;
    for (int j = 0; j < 3; j++) begin
      e.rd[j]  = model_rd(j, a);
      e.irq[j] = |(m_ecap[j] & m_mask[j]);
    end
    sb.push_back(e);
  endtask

  task automatic rd_c(input logic [1:0] a);
    step(1'b1, cur_pins, 1'b1, 1'b1, a, 32'h0);
  endtask

  task automatic wr_c(input logic [1:0] a, input logic [31:0] d);
    step(1'b1, cur_pins, 1'b1, 1'b0, a, d);
  endtask

  task automatic wait_c(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) rd_c(a);
  endtask

  // Monitor: one expected entry per cycle; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: got no expected entry, required one per cycle");
        end else begin
          e = sb.pop_front();
          for (int j = 0; j < 3; j++) begin
            checks++;
            if (dut_rd[j] !== e.rd[j]) begin
              errors++;
              $display("FAIL readdata dut%0d addr %0d: got %08h required %08h", j, e.addr, dut_rd[j], e.rd[j]);
            end
            checks++;
            if (dut_irq[j] !== e.irq[j]) begin
              errors++;
              $display("FAIL irq dut%0d: got %0b required %0b", j, dut_irq[j], e.irq[j]);
            end
          end
          if (e.cs)
            $display("t=%0t %s addr=%0d wd=%08h rd={%08h,%08h,%08h} irq=%03b pins=%h",
                     $time, e.wn ? "RD" : "WR", e.addr, e.wd, dut_rd[0], dut_rd[1], dut_rd[2],
                     dut_irq, in_port);
        end
      end
    end
  end

  initial begin
    logic [1:0]  a;
    logic [31:0] d;
    int r;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    model_reset();
    mon_en = 1'b1;

    // Reset state, all addresses, then after release
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b1, 2'(i), 32'h0);
    for (int i = 0; i < 4; i++) rd_c(2'(i));

    // 0000 -> 0101, mask bit 2, clear bit 2
    cur_pins = 4'h5;
    wait_c(4, 2'd0); wait_c(2, 2'd3);
    wr_c(2'd2, 32'h4); rd_c(2'd3);
    wr_c(2'd3, 32'h4); rd_c(2'd3); rd_c(2'd0);

    // Glitch rejection on bit 0 (short vs long pulse)
    cur_pins = 4'h4; wait_c(8, 2'd0); wr_c(2'd3, 32'hF);
    cur_pins = 4'h5; wait_c(3, 2'd0);
    cur_pins = 4'h4; wait_c(8, 2'd3);
    cur_pins = 4'h5; wait_c(6, 2'd0);
    cur_pins = 4'h4; wait_c(8, 2'd3);

    // Bit 2 fall / rise / fall
    cur_pins = 4'h0; wait_c(8, 2'd3); wr_c(2'd3, 32'hF);
    cur_pins = 4'h4; wait_c(8, 2'd3);
    cur_pins = 4'h0; wait_c(8, 2'd3);

    // Clear of bit 1 coinciding with a new rising edge on bit 1
    wr_c(2'd2, 32'hF);
    cur_pins = 4'h2; wait_c(6, 2'd3);
    cur_pins = 4'h0; wait_c(6, 2'd3);
    cur_pins = 4'h2; rd_c(2'd3); rd_c(2'd3); rd_c(2'd3);
    wr_c(2'd3, 32'h2); wait_c(3, 2'd3);

    // Writes to read-only / reserved, mask truncation
    wr_c(2'd0, 32'hFFFF_FFFF); wr_c(2'd1, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) rd_c(2'(i));
    wr_c(2'd2, 32'hFFFF_FFF3); rd_c(2'd2);

    // Reset mid-debounce, released with pins low
    wr_c(2'd3, 32'hF);
    cur_pins = 4'hF; wait_c(2, 2'd0);
    step(1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 32'h0);
    step(1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 32'h0);
    cur_pins = 4'h0; wait_c(10, 2'd3);

    // Reset released with pins high
    step(1'b0, 4'hF, 1'b1, 1'b1, 2'd3, 32'h0);
    cur_pins = 4'hF; wait_c(10, 2'd3);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) cur_pins = cur_pins ^ 4'($urandom_range(1, 15));
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 299) == 0)
        step(1'b0, cur_pins, 1'b0, 1'b1, a, d);
      else if (r < 5)
        rd_c(a);
      else if (r < 8)
        wr_c(a, d);
      else
        step(1'b1, cur_pins, 1'b0, 1'b0, a, d);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
